// File: rtl/kb_read_arbiter.sv
// Round-robin read arbiter between keyboard_buf and its CPU / echo consumers.
// Also sequences buffer flushes and counts characters dropped on a full buffer.
module kb_read_arbiter #(
   parameter int unsigned CLR_CYCLES = 2,
   parameter int unsigned DROP_W     = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              kb_status,
   input  logic [6:0]        kb_data,
   input  logic              buf_full,
   input  logic              rx_done,
   output logic              kb_read_en,
   output logic              kb_clear,
   input  logic              cpu_req,
   input  logic              cpu_clr,
   input  logic              echo_req,
   output logic              cpu_ack,
   output logic              echo_ack,
   output logic [6:0]        rd_data,
   output logic              busy,
   output logic [DROP_W-1:0] drop_cnt
);

   localparam int unsigned CNT_W = 4;
   localparam logic [DROP_W-1:0] DROP_MAX = '1;

   typedef enum logic [1:0] {IDLE, READ, ACK, CLEAR} state_t;

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] clr_cnt;
   logic             clr_pending;
   logic             grant_echo;
   logic             last_echo;
   logic             grant_sel;
   logic             clr_entry;
   logic             read_entry;
   logic             drop_evt;

   // On a tie the requester that did not win last time is chosen
   assign grant_sel  = (cpu_req && echo_req) ? ~last_echo : echo_req;
   assign clr_entry  = (state == IDLE) && (state_nxt == CLEAR);
   assign read_entry = (state == IDLE) && (state_nxt == READ);
   assign drop_evt   = rx_done && buf_full;

   always_ff @(posedge clk) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (clr_pending || cpu_clr)
               state_nxt = CLEAR;
            else if (kb_status && (cpu_req || echo_req))
               state_nxt = READ;
         end
         READ:    state_nxt = ACK;
         ACK:     state_nxt = IDLE;
         CLEAR:   if (clr_cnt <= CNT_W'(1)) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      kb_read_en = 1'b0;
      kb_clear   = 1'b0;
      cpu_ack    = 1'b0;
      echo_ack   = 1'b0;
      busy       = (state != IDLE);
      case (state)
         READ:  kb_read_en = 1'b1;
         ACK: begin
            cpu_ack  = ~grant_echo;
            echo_ack = grant_echo;
         end
         CLEAR: kb_clear = 1'b1;
         default: ;
      endcase
   end

   // Grant, captured data, flush bookkeeping and drop counter
   always_ff @(posedge clk) begin
      if (!reset) begin
         clr_cnt     <= '0;
         clr_pending <= 1'b0;
         grant_echo  <= 1'b0;
         last_echo   <= 1'b1;
         rd_data     <= '0;
         drop_cnt    <= '0;
      end else begin
         if (clr_entry)
            clr_cnt <= CNT_W'(CLR_CYCLES);
         else if (state == CLEAR)
            clr_cnt <= clr_cnt - CNT_W'(1);

         if (clr_entry)
            clr_pending <= 1'b0;
         else if (cpu_clr)
            clr_pending <= 1'b1;

         if (read_entry) begin
            grant_echo <= grant_sel;
            last_echo  <= grant_sel;
         end

         if (state == READ)
            rd_data <= kb_data;

         if (clr_entry)
            drop_cnt <= '0;
         else if (drop_evt && (drop_cnt != DROP_MAX))
            drop_cnt <= drop_cnt + DROP_W'(1);
      end
   end

endmodule

// File: tb/tb_kb_read_arbiter.sv
// Randomized bench for kb_read_arbiter: a character-queue environment plus a
// schedule-based reference model predicting every output each cycle.
module tb_kb_read_arbiter;

   localparam int unsigned CLR_CYCLES = 2;
   localparam int unsigned DROP_W     = 2;
   localparam int          DROP_MAX   = (1 << DROP_W) - 1;
   localparam int          N_CYCLES   = 7000;

   logic              clk = 1'b0;
   logic              reset;
   logic              kb_status;
   logic [6:0]        kb_data;
   logic              buf_full;
   logic              rx_done;
   logic              kb_read_en;
   logic              kb_clear;
   logic              cpu_req;
   logic              cpu_clr;
   logic              echo_req;
   logic              cpu_ack;
   logic              echo_ack;
   logic [6:0]        rd_data;
   logic              busy;
   logic [DROP_W-1:0] drop_cnt;

   int checks = 0;
   int errors = 0;

   logic [6:0] fifo[$];   // contents of the keyboard buffer
   logic [6:0] mq[$];     // characters the model has not yet seen read
   logic [3:0] sched[$];  // upcoming cycles: {read_en, clear, cpu_ack, echo_ack}
   logic [3:0] cur;
   bit         cur_idle;
   bit         pend;
   bit         last_echo;
   bit         pop_due;
   int         drop_exp;
   logic [6:0] rd_exp;

   kb_read_arbiter #(.CLR_CYCLES(CLR_CYCLES), .DROP_W(DROP_W)) dut (
      .clk        (clk),
      .reset      (reset),
      .kb_status  (kb_status),
      .kb_data    (kb_data),
      .buf_full   (buf_full),
      .rx_done    (rx_done),
      .kb_read_en (kb_read_en),
      .kb_clear   (kb_clear),
      .cpu_req    (cpu_req),
      .cpu_clr    (cpu_clr),
      .echo_req   (echo_req),
      .cpu_ack    (cpu_ack),
      .echo_ack   (echo_ack),
      .rd_data    (rd_data),
      .busy       (busy),
      .drop_cnt   (drop_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Advance the model across one clock edge using the inputs present at it
   task automatic model_step();
      logic [6:0] ch;
      bit         enter;
      bit         g_echo;
      ch    = '0;
      enter = 1'b0;
      if (cur[3] && mq.size() > 0) ch = mq.pop_front();
      if (!reset) begin
         sched.delete();
         cur       = '0;
         cur_idle  = 1'b1;
         pend      = 1'b0;
         last_echo = 1'b1;
         drop_exp  = 0;
         rd_exp    = '0;
         return;
      end
      if (cur[3]) rd_exp = ch;
      if (cur_idle) begin
         if (pend || cpu_clr) begin
            enter = 1'b1;
            repeat (CLR_CYCLES) sched.push_back(4'b0100);
         end else if (kb_status && (cpu_req || echo_req)) begin
            g_echo    = (cpu_req && echo_req) ? !last_echo : echo_req;
            last_echo = g_echo;
            sched.push_back(4'b1000);
            sched.push_back(g_echo ? 4'b0001 : 4'b0010);
         end
      end
      pend = enter ? 1'b0 : (pend | cpu_clr);
      if (enter)
         drop_exp = 0;
      else if (rx_done && buf_full && drop_exp < DROP_MAX)
         drop_exp = drop_exp + 1;
      if (sched.size() > 0) begin
         cur      = sched.pop_front();
         cur_idle = 1'b0;
      end else begin
         cur      = '0;
         cur_idle = 1'b1;
      end
   endtask

   task automatic drive(input int p_arr, input int p_req, input int p_clr,
                        input int p_full, input int p_rst, input bit both);
      logic [6:0] c;
      reset = ($urandom_range(0, 999) < p_rst) ? 1'b0 : 1'b1;
      if (fifo.size() < 8 && $urandom_range(0, 99) < p_arr) begin
         c = 7'($urandom);
         fifo.push_back(c);
         mq.push_back(c);
      end
      kb_status = (fifo.size() > 0);
      kb_data   = kb_status ? fifo[0] : 7'($urandom);
      if (both) begin
         cpu_req  = 1'b1;
         echo_req = 1'b1;
      end else begin
         if ($urandom_range(0, 99) < p_req) cpu_req  = ~cpu_req;
         if ($urandom_range(0, 99) < p_req) echo_req = ~echo_req;
      end
      cpu_clr  = ($urandom_range(0, 99) < p_clr);
      rx_done  = ($urandom_range(0, 99) < 40);
      buf_full = ($urandom_range(0, 99) < p_full);
   endtask

   initial begin
      logic [6:0] tmp;
      reset     = 1'b0;
      kb_status = 1'b0;
      kb_data   = '0;
      buf_full  = 1'b0;
      rx_done   = 1'b0;
      cpu_req   = 1'b0;
      cpu_clr   = 1'b0;
      echo_req  = 1'b0;
      cur       = '0;
      cur_idle  = 1'b1;
      pend      = 1'b0;
      last_echo = 1'b1;
      pop_due   = 1'b0;
      drop_exp  = 0;
      rd_exp    = '0;

      for (int cyc = 0; cyc < N_CYCLES; cyc++) begin
         @(posedge clk);
         model_step();
         @(negedge clk);
         if (pop_due && fifo.size() > 0) tmp = fifo.pop_front();
         check("kb_read_en", int'(kb_read_en), int'(cur[3]));
         check("kb_clear",   int'(kb_clear),   int'(cur[2]));
         check("cpu_ack",    int'(cpu_ack),    int'(cur[1]));
         check("echo_ack",   int'(echo_ack),   int'(cur[0]));
         check("busy",       int'(busy),       int'(|cur));
         check("rd_data",    int'(rd_data),    int'(rd_exp));
         check("drop_cnt",   int'(drop_cnt),   drop_exp);
         pop_due = kb_read_en;
         if (cyc < 4)
            drive(30, 0, 0, 0, 1000, 1'b0);
         else if (cyc < 3000)
            drive(30, 10, 1, 20, 3, 1'b0);
         else if (cyc < 4500)
            drive(15, 20, 1, 90, 2, 1'b0);
         else if (cyc < 6000)
            drive(40, 15, 8, 60, 15, 1'b0);
         else
            drive(60, 0, 1, 30, 2, 1'b1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/kb_read_arbiter.md
Name: kb_read_arbiter

Overview:
Sits between keyboard_buf and its two consumers: the CPU memory-mapped keyboard port and the terminal echo unit. Grants single-character reads round-robin, drives the buffer's KB_read_en and KB_clear with clean one-state pulses, and returns each character with an ack strobe. Also sequences CPU-requested buffer flushes and counts characters dropped while the buffer is full.

Parameters:
CLR_CYCLES, 2, cycles kb_clear is held high during a flush (1..15)
DROP_W, 8, width of the saturating dropped-character counter

Ports:
clk  input  1  system clock; all logic on posedge
reset  input  1  synchronous, active-low reset
kb_status  input  1  buffer non-empty (KB_status)
kb_data  input  7  head-of-FIFO character (KB_data), combinationally valid while kb_status=1
buf_full  input  1  buffer full
rx_done  input  1  UART byte-received strobe, also routed to keyboard_buf
kb_read_en  output  1  pop strobe to buffer
kb_clear  output  1  flush to buffer
cpu_req  input  1  CPU wants one character (level)
cpu_clr  input  1  CPU flush request (single-cycle pulse)
echo_req  input  1  echo unit wants one character (level)
cpu_ack  output  1  one-cycle strobe; rd_data valid for CPU
echo_ack  output  1  one-cycle strobe; rd_data valid for echo
rd_data  output  7  last character popped
busy  output  1  state != IDLE
drop_cnt  output  DROP_W  characters lost to a full buffer

Behaviour:
- States: IDLE, READ, ACK, CLEAR. All outputs are registered or decoded from the state.
- Reset (reset=0 at posedge): state=IDLE, kb_read_en=0, kb_clear=0, both acks=0, rd_data=0, drop_cnt=0, clr_pending=0, last_grant=ECHO, so the CPU wins the first tie.
- clr_pending is set by cpu_clr in any state. It is cleared on entry to CLEAR.
- IDLE priority:
  - clr_pending or cpu_clr -> CLEAR, with counter=CLR_CYCLES.
  - Else, if kb_status=1 and any req is high -> READ. Grant goes to the sole requester. If both request, grant goes to the one not equal to last_grant. The grant is latched and last_grant is updated.
  - Else stay in IDLE.
  - A request with kb_status=0 waits; it is never acked with stale data.
- READ (exactly 1 cycle): kb_read_en=1; rd_data<=kb_data at the end of the cycle; -> ACK.
- ACK (exactly 1 cycle): the granted requester's ack=1, the other ack=0; rd_data holds its value until the next READ; -> IDLE.
- Latency: req high at edge N in IDLE -> kb_read_en high during cycle N+1 -> ack high during cycle N+2. Peak rate is 1 character per 3 cycles.
- Requesters must drop req in the cycle after ack. A req still high in IDLE is served again.
- cpu_clr during READ/ACK: the current transfer completes and is acked normally, then CLEAR is entered from IDLE.
- CLEAR: kb_clear=1 for CLR_CYCLES cycles, then IDLE. No reads are granted and no acks are issued. Reqs held across CLEAR are evaluated in IDLE afterwards, and only if kb_status=1.
- drop_cnt:
  - Increments by 1 when rx_done=1 and buf_full=1 in the same cycle.
  - Saturates at 2^DROP_W-1.
  - Cleared on entry to CLEAR. If entry to CLEAR and a drop occur in the same cycle, the result is 0.
- Reset mid-operation (any state) returns to the reset values on the next edge. kb_clear and kb_read_en deassert at that edge.
- kb_read_en and kb_clear are never high in the same cycle. At most one ack is high per cycle.

Test Plan:
- Single CPU read: FIFO holds 'A' (0x41), cpu_req high at edge 0 -> kb_read_en high cycle 1 only; cpu_ack high cycle 2 with rd_data=0x41; echo_ack stays 0.
- Round-robin: FIFO holds 0x31,0x32,0x33,0x34; both reqs held high continuously -> acks alternate CPU,ECHO,CPU,ECHO with 0x31..0x34 every 3 cycles; then kb_status=0 -> no further kb_read_en.
- Empty wait: cpu_req high with empty FIFO for 10 cycles -> no kb_read_en, no ack; a char 0x0D arrives -> read 1 cycle after kb_status rises, ack 1 cycle later with 0x0D.
- Flush mid-transfer: cpu_clr pulsed during READ -> ack for the in-flight char still issued; then kb_clear high exactly 2 cycles; drop_cnt=0; busy low after.
- Drop counting: DROP_W=2, buf_full=1, 5 rx_done strobes -> drop_cnt 1,2,3,3,3. A cpu_clr flush then zeroes it; a drop on the CLEAR-entry cycle still reads 0.
- Reset: reset=0 asserted during CLEAR and during ACK -> next cycle all outputs 0, state IDLE; first tie after reset is granted to the CPU.
